// File: rtl/rr_arb8_16b.sv
// Round-robin arbiter/sequencer for the shared 8-input 16-bit datapath mux.
// Grants one requester per burst and forwards its words over valid/ready.

module mux8_1_16b (
  input  logic [127:0] in_data,
  input  logic [2:0]   sel,
  output logic [15:0]  out_data
);

  // Select one 16-bit slice of the packed requester words
  always_comb begin
    out_data = 16'h0000;
    case (sel)
      3'd0:    out_data = in_data[15:0];
      3'd1:    out_data = in_data[31:16];
      3'd2:    out_data = in_data[47:32];
      3'd3:    out_data = in_data[63:48];
      3'd4:    out_data = in_data[79:64];
      3'd5:    out_data = in_data[95:80];
      3'd6:    out_data = in_data[111:96];
      3'd7:    out_data = in_data[127:112];
      default: out_data = 16'h0000;
    endcase
  end

endmodule

module rr_arb8_16b #(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   req,
  input  logic [7:0]   last,
  input  logic [127:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [15:0]  out_data,
  output logic         out_last,
  output logic [2:0]   sel,
  output logic [7:0]   grant,
  output logic [7:0]   ack,
  output logic         busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] LIMIT_M1 = 8'(MAX_BEATS - 1);

  state_t      state_r;
  logic [2:0]  ptr_r;
  logic [2:0]  sel_r;
  logic [7:0]  grant_r;
  logic [7:0]  beat_cnt_r;

  logic [2:0]  win_s;
  logic        xfer_s;
  logic        last_s;
  logic [15:0] mux_data_s;

  // First set request bit scanning ptr, ptr+1, ... (mod 8)
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx   = p + 3'(k);
      res   = (!found && r[idx]) ? idx : res;
      found = found | r[idx];
    end
    return res;
  endfunction

  assign win_s = rr_pick(req, ptr_r);

  mux8_1_16b u_mux (
    .in_data  (in_data),
    .sel      (sel_r),
    .out_data (mux_data_s)
  );

  // Transfer qualification and end-of-grant detection
  always_comb begin
    xfer_s = 1'b0;
    last_s = 1'b0;
    ack    = 8'h00;
    if (state_r == GRANT) begin
      xfer_s = out_ready;
      last_s = last[sel_r] | (beat_cnt_r == LIMIT_M1);
    end else begin
      xfer_s = 1'b0;
      last_s = 1'b0;
    end
    // A reset cycle aborts the burst, so no beat is acknowledged in it
    if (xfer_s && rst_n) begin
      ack = grant_r;
    end else begin
      ack = 8'h00;
    end
  end

  assign out_valid = (state_r == GRANT);
  assign busy      = (state_r == GRANT);
  assign out_last  = last_s;
  assign out_data  = mux_data_s;
  assign sel       = sel_r;
  assign grant     = grant_r;

  // Arbitration / burst sequencing state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= 3'd0;
      sel_r      <= 3'd0;
      grant_r    <= 8'h00;
      beat_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req != 8'h00) begin
            sel_r      <= win_s;
            grant_r    <= 8'd1 << win_s;
            beat_cnt_r <= 8'd0;
            state_r    <= GRANT;
          end else begin
            state_r    <= IDLE;
          end
        end
        GRANT: begin
          if (xfer_s) begin
            if (last_s) begin
              // Clearing on release keeps the count below MAX_BEATS
              state_r    <= IDLE;
              grant_r    <= 8'h00;
              ptr_r      <= sel_r + 3'd1;
              beat_cnt_r <= 8'd0;
            end else begin
              beat_cnt_r <= beat_cnt_r + 8'd1;
            end
          end else begin
            state_r <= GRANT;
          end
        end
        default: begin
          state_r    <= IDLE;
          grant_r    <= 8'h00;
          beat_cnt_r <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb8_16b.sv
// Self-checking bench: two arbiter instances (MAX_BEATS 16 and 4) on shared
// inputs, checked every cycle against a burst-level reference model.

module tb_rr_arb8_16b;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [7:0]   last;
  logic [127:0] in_data;
  logic         out_ready;

  logic [1:0]        ov;
  logic [1:0][15:0]  od;
  logic [1:0]        ol;
  logic [1:0][2:0]   sl;
  logic [1:0][7:0]   gr;
  logic [1:0][7:0]   ak;
  logic [1:0]        bz;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: per instance, burst in progress, owner, beats done, pointer
  bit m_busy [2];
  int m_sel  [2];
  int m_cnt  [2];
  int m_ptr  [2];
  int lim    [2];

  int   log0[$];
  int   log1[$];
  bit   prev_ov [2];
  int   ack_cnt0 [8];
  int   ack_cnt1 [8];
  int   lastx0, lastx1;
  logic [7:0] snap_ack0, snap_gr0;
  logic [2:0] snap_sl0;

  rr_arb8_16b #(.MAX_BEATS(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .in_data(in_data),
    .out_ready(out_ready), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
    .sel(sl[0]), .grant(gr[0]), .ack(ak[0]), .busy(bz[0])
  );

  rr_arb8_16b #(.MAX_BEATS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .in_data(in_data),
    .out_ready(out_ready), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
    .sel(sl[1]), .grant(gr[1]), .ack(ak[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input int k);
    logic [7:0] eg, ea;
    logic       el;
    eg = m_busy[k] ? (8'd1 << m_sel[k]) : 8'd0;
    ea = (m_busy[k] && out_ready && rst_n) ? eg : 8'd0;
    el = m_busy[k] && (last[m_sel[k]] || (m_cnt[k] + 1 == lim[k]));
    check($sformatf("grant%0d", k), 32'(gr[k]), 32'(eg));
    check($sformatf("ack%0d", k), 32'(ak[k]), 32'(ea));
    check($sformatf("valid%0d", k), 32'(ov[k]), 32'(m_busy[k]));
    check($sformatf("busy%0d", k), 32'(bz[k]), 32'(m_busy[k]));
    check($sformatf("sel%0d", k), 32'(sl[k]), 32'(m_sel[k]));
    check($sformatf("olast%0d", k), 32'(ol[k]), 32'(el));
    if (m_busy[k]) check($sformatf("data%0d", k), 32'(od[k]), 32'(in_data[m_sel[k]*16 +: 16]));
  endtask

  task automatic model_update(input int k);
    if (!rst_n) begin
      m_busy[k] = 1'b0; m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
    end else if (!m_busy[k]) begin
      for (int i = 0; i < 8; i++) begin
        if (req[(m_ptr[k] + i) % 8]) begin
          m_sel[k]  = (m_ptr[k] + i) % 8;
          m_busy[k] = 1'b1;
          m_cnt[k]  = 0;
          break;
        end
      end
    end else if (out_ready) begin
      m_cnt[k]++;
      if (last[m_sel[k]] || m_cnt[k] == lim[k]) begin
        m_busy[k] = 1'b0;
        m_ptr[k]  = (m_sel[k] + 1) % 8;
      end
    end
  endtask

  // one clock: check at negedge, advance model at posedge, then allow new drive
  task automatic step();
    @(negedge clk);
    compare(0);
    compare(1);
    if (ov[0] && !prev_ov[0]) log0.push_back(int'(sl[0]));
    if (ov[1] && !prev_ov[1]) log1.push_back(int'(sl[1]));
    prev_ov[0] = ov[0];
    prev_ov[1] = ov[1];
    for (int i = 0; i < 8; i++) begin
      if (ak[0][i]) ack_cnt0[i]++;
      if (ak[1][i]) ack_cnt1[i]++;
    end
    if (ak[0] != 8'h00 && ol[0]) lastx0++;
    if (ak[1] != 8'h00 && ol[1]) lastx1++;
    snap_ack0 = ak[0];
    snap_gr0  = gr[0];
    snap_sl0  = sl[0];
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) begin
      ack_cnt0[i] = 0;
      ack_cnt1[i] = 0;
    end
    lastx0 = 0;
    lastx1 = 0;
  endtask

  initial begin
    int n;
    lim[0] = 16;
    lim[1] = 4;
    rst_n     = 1'b0;
    req       = 8'h00;
    last      = 8'h00;
    out_ready = 1'b0;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0; prev_ov[k] = 1'b0;
    end
    #1;
    clear_counts();

    // 1: reset, then idle with no requests
    step();
    rst_n = 1'b1;
    repeat (10) step();

    // 2: requesters 0 and 7, single-beat bursts, pointer wraps 7 -> 0
    req = 8'h81; last = 8'hFF; out_ready = 1'b1;
    n = log0.size();
    repeat (6) step();
    check("t2_ngrants", 32'(log0.size() - n), 32'd3);
    if (log0.size() - n >= 3) begin
      check("t2_first", 32'(log0[n]), 32'd0);
      check("t2_second", 32'(log0[n+1]), 32'd7);
      check("t2_third", 32'(log0[n+2]), 32'd0);
    end
    req = 8'h00;
    repeat (2) step();

    // 3: requester 3 alone, ready toggling, last on 4th beat
    clear_counts();
    in_data[63:48] = 16'hBEEF;
    req = 8'h08;
    n = 0;
    while (ack_cnt0[3] < 4 && n < 40) begin
      out_ready = (n % 2 == 0);
      last = (ack_cnt0[3] == 3) ? 8'h08 : 8'h00;
      step();
      n++;
    end
    req = 8'h00; last = 8'h00; out_ready = 1'b1;
    repeat (3) step();
    check("t3_acks", 32'(ack_cnt0[3]), 32'd4);
    check("t3_lastx", 32'(lastx0), 32'd1);

    // 4: beat limit 4 on the small instance, requester 5 never signals last
    clear_counts();
    req = 8'h60; last = 8'h00; out_ready = 1'b1;
    n = log1.size();
    repeat (8) step();
    check("t4_acks5", 32'(ack_cnt1[5]), 32'd4);
    check("t4_lastx", 32'(lastx1), 32'd1);
    check("t4_ngrants", 32'(log1.size() - n), 32'd2);
    if (log1.size() - n >= 2) begin
      check("t4_first", 32'(log1[n]), 32'd5);
      check("t4_next", 32'(log1[n+1]), 32'd6);
    end

    // 5: everyone requesting, single-beat bursts -> 0..7,0
    req = 8'h00; rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 8'hFF; last = 8'hFF;
    n = log0.size();
    repeat (18) step();
    check("t5_ngrants", 32'(log0.size() - n), 32'd9);
    if (log0.size() - n >= 9) begin
      for (int i = 0; i < 9; i++) check($sformatf("t5_order%0d", i), 32'(log0[n+i]), 32'(i % 8));
    end

    // 6: reset during the second beat of a burst
    req = 8'h00; rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 8'hFF; last = 8'h00; out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("t6_noack", 32'(snap_ack0), 32'd0);
    rst_n = 1'b1;
    step();
    check("t6_rst_grant", 32'(snap_gr0), 32'd0);
    step();
    check("t6_regrant", 32'(snap_gr0), 32'h01);
    check("t6_resel", 32'(snap_sl0), 32'd0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      req       = 8'($urandom) & 8'($urandom);
      last      = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      rst_n     = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arb8_16b.md
# rr_arb8_16b

Round-robin arbiter and sequencer for the shared 8-input, 16-bit datapath mux (mux8_1_16b).
- Eight requesters each present a 16-bit data word and a request.
- The block grants one requester at a time, drives the mux select, and forwards the selected word to a single downstream consumer over a valid/ready handshake.
- A grant is held for a multi-beat burst until the requester's last beat or a beat-count limit.
- Sits between the requester bank and the shared 16-bit bus.

## Interface
Parameters:
- MAX_BEATS, 16, maximum beats per grant before forced release (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  8  request per requester; bit i = requester i.
- last  in  8  last-beat flag per requester; sampled only for the granted requester.
- in_data  in  128  requester data; requester i occupies bits [16i+15:16i].
- out_ready  in  1  downstream can accept a beat this cycle.
- out_valid  out  1  out_data holds a valid beat.
- out_data  out  16  selected requester's word, routed through an internal mux8_1_16b.
- out_last  out  1  current beat ends the grant (requester last, or beat limit reached).
- sel  out  3  binary index of the granted requester; drives the mux select.
- grant  out  8  one-hot grant; all zero when idle.
- ack  out  8  one-hot; bit i high in the cycle requester i's beat transfers.
- busy  out  1  high in GRANT state.

## Operation
- States: IDLE and GRANT.
- Registered state: ptr (3 bits, highest-priority index), sel, beat count (8 bits).
- **IDLE**
  - grant=0, out_valid=0.
  - If req != 0, pick the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Register sel = winner and grant = 1<<winner, clear beat count, go to GRANT.
- **GRANT**
  - out_valid = 1, busy = 1, out_data = in_data[16·sel+15 : 16·sel].
  - A transfer occurs when out_valid && out_ready. ack[sel] = 1 in that cycle only.
  - On each transfer, beat count increments.
  - out_last = last[sel] OR (beat count == MAX_BEATS−1). Combinational, valid whenever out_valid.
  - Transfer with out_last = 1: go to IDLE, clear grant, set ptr = sel+1 (mod 8; 7 wraps to 0).
  - Requester dropping req mid-grant is ignored. The grant persists until out_last transfers, so requesters must keep data stable until acked.
  - out_ready low stalls. State, sel, beat count and out_data (given stable in_data) all hold.
- ptr changes only on release, so each requester waits at most 7 grants.
- Single requester: it re-wins every arbitration; ptr still advances past it.

## Timing
- Reset (rst_n low at a clock edge) values: state=IDLE, ptr=0, sel=0, grant=0, beat count=0, out_valid=0, out_last=0, ack=0, busy=0.
- Reset mid-grant aborts the burst with no ack that cycle. The first post-reset arbitration starts at ptr=0.
- Arbitration latency: req sampled in IDLE at edge N gives grant/out_valid high after edge N (one cycle).
- Release: last transfer at edge M gives IDLE after M. Earliest next grant is after M+1, so there is one dead cycle between grants.
- ack, out_valid, out_last and out_data are combinational from registered state plus last, out_ready and in_data. There is no combinational path from req to outputs.
- Beat limit: with MAX_BEATS=N, the Nth beat carries out_last=1 regardless of last[sel].
- MAX_BEATS=1: every beat releases.
- Beat count never exceeds MAX_BEATS−1.

## Test plan
1. Reset then req=8'h00 for 10 cycles → grant=0, out_valid=0, sel=0, busy=0 throughout.
2. req=8'h81, last=8'hFF, out_ready=1, with reset ptr=0 → requester 0 granted first (sel=0, ack=8'h01). Next grant goes to requester 7 (sel=7). Following grant returns to requester 0 (ptr wrapped 7→0).
3. Requester 3 alone, in_data slice 3 = 16'hBEEF, last[3] asserted on 4th beat, out_ready toggling 1,0,1,0… → exactly 4 acks. out_data=16'hBEEF on each. out_last only on the 4th transfer. State held during ready-low cycles.
4. MAX_BEATS=4, requester 5 holds last=0 → forced out_last on 4th transfer. Grant then goes to next requester (6) if requesting.
5. All eight requesting continuously, last=all ones → grant order 0,1,2,…,7,0. Each grant is separated by one idle cycle.
6. Assert rst_n=0 during the 2nd beat of a burst → outputs go to reset values the next cycle with no ack. After release with req=8'hFF, requester 0 is granted.
